// File: rtl/ght_update_arbiter_pkg.sv
// ght_update_arbiter_pkg: shared history-table update encodings, checkpoint width, arbiter types
package ght_update_arbiter_pkg;
  localparam int CKPT_W = 16;
  localparam int ACT_W = 5;
  localparam int NEED_REPAIR = 0;
  localparam int PHT_LO = 1;
  localparam int PHT_HI = 2;
  localparam int IJTC_LO = 3;
  localparam int IJTC_HI = 4;
  localparam logic [1:0] ACT_NONE = 2'd0;
  localparam logic [1:0] PHT_DIRECT = 2'd1;
  localparam logic [1:0] PHT_REPAIRE = 2'd2;
  localparam logic [1:0] IJTC_REPAIRE = 2'd2;
  typedef enum logic [1:0] {IDLE, DRAIN, BLOCK} state_e;
  typedef struct packed {
    logic take;
    logic [31:0] vaddr;
    logic [CKPT_W-1:0] ckpt;
  } dir_entry_t;
  function automatic logic [ACT_W-1:0] mk_action(logic [1:0] pht, logic [1:0] ijtc);
    return {ijtc, pht, 1'b1};
  endfunction
endpackage

// File: rtl/ght_update_arbiter_fifo.sv
// upd_fifo: direct-update queue with synchronous flush
//   push_i/data_i write, pop_i/data_o read head, count_o occupancy, full_o/empty_o status
module upd_fifo import ght_update_arbiter_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  dir_entry_t               data_i,
  input  logic                     pop_i,
  output dir_entry_t               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  dir_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic pu, po;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign pu = push_i && !full_o && !flush_i;
  assign po = pop_i && !empty_o && !flush_i;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (pu) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(pu);
      rd_q <= rd_q + AW'(po);
      cnt_q <= cnt_q + CW'(pu) - CW'(po);
    end
  end
endmodule

// File: rtl/ght_update_arbiter.sv
// ght_update_arbiter: merges frontend direct updates and backend repairs into one registered history-table update stream
//   DIR_* queued direct updates (DIR_ready_o handshake), REP_* repairs (always accepted, flush queue, open refusal window)
//   GHT_* registered update fields, ARB_pending_o queue occupancy
module ght_update_arbiter import ght_update_arbiter_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int BLOCK_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   DIR_valid_i,
  output logic                   DIR_ready_o,
  input  logic                   DIR_take_i,
  input  logic [31:0]            DIR_vAddr_i,
  input  logic [CKPT_W-1:0]      DIR_checkPoint_i,
  input  logic                   REP_valid_i,
  input  logic                   REP_isPHT_i,
  input  logic [31:0]            REP_vAddr_i,
  input  logic                   REP_take_i,
  input  logic [31:0]            REP_dest_i,
  input  logic [CKPT_W-1:0]      REP_checkPoint_i,
  output logic [ACT_W-1:0]       GHT_repairAction_o,
  output logic [CKPT_W-1:0]      GHT_allCheckPoint_o,
  output logic [31:0]            GHT_erroVAddr_o,
  output logic                   GHT_correctTake_o,
  output logic [31:0]            GHT_correctDest_o,
  output logic [$clog2(DEPTH):0] ARB_pending_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(BLOCK_CYC + 2);
  state_e state_q, state_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [ACT_W-1:0] act_q, act_d;
  logic [CKPT_W-1:0] ckpt_q, ckpt_d;
  logic [31:0] vaddr_q, vaddr_d, dest_q, dest_d;
  logic take_q, take_d;
  logic push, pop, full, empty;
  logic [CW-1:0] count;
  dir_entry_t head;
  assign push = DIR_valid_i && DIR_ready_o;
  assign pop = !REP_valid_i && !empty;
  upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (REP_valid_i),
    .push_i  (push),
    .data_i  ({DIR_take_i, DIR_vAddr_i, DIR_checkPoint_i}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q <= '0;
      act_q <= '0;
      ckpt_q <= '0;
      vaddr_q <= '0;
      take_q <= 1'b0;
      dest_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q <= blk_d;
      act_q <= act_d;
      ckpt_q <= ckpt_d;
      vaddr_q <= vaddr_d;
      take_q <= take_d;
      dest_q <= dest_d;
    end
  end
  // The window ends on the edge where the counter would fall from 1 to 0, so
  // exactly BLOCK_CYC cycles after the repair cycle are refused.
  always_comb begin
    blk_d = REP_valid_i ? BW'(BLOCK_CYC) : (blk_q != '0 ? blk_q - 1'b1 : '0);
    state_d = REP_valid_i ? BLOCK :
              (state_q == BLOCK && blk_q > BW'(1)) ? BLOCK :
              (push || count > CW'(pop)) ? DRAIN : IDLE;
  end
  always_comb begin
    DIR_ready_o = !full && state_q != BLOCK && !REP_valid_i;
    act_d = REP_valid_i ? (REP_isPHT_i ? mk_action(PHT_REPAIRE, ACT_NONE) : mk_action(ACT_NONE, IJTC_REPAIRE)) :
            pop ? mk_action(PHT_DIRECT, ACT_NONE) : '0;
    ckpt_d = REP_valid_i ? REP_checkPoint_i : pop ? head.ckpt : '0;
    vaddr_d = REP_valid_i ? REP_vAddr_i : pop ? head.vaddr : '0;
    take_d = REP_valid_i ? REP_take_i : pop && head.take;
    dest_d = REP_valid_i ? REP_dest_i : '0;
  end
  assign GHT_repairAction_o = act_q;
  assign GHT_allCheckPoint_o = ckpt_q;
  assign GHT_erroVAddr_o = vaddr_q;
  assign GHT_correctTake_o = take_q;
  assign GHT_correctDest_o = dest_q;
  assign ARB_pending_o = count;
endmodule
